// File: rtl/vdp_scroll_tile_fetcher_if.sv
// ---------------------------------------------------------------------------
// vdp_scroll_tile_fetcher_if
// VRAM read channel between a scroll-layer tile fetcher and the VRAM read
// arbiter. Requests use a valid/ready handshake. Read data returns in order
// with its own valid strobe, at least one cycle after the request is accepted.
//
// Signals
//   vram_read_valid       fetcher -> arbiter  request valid
//   vram_read_ready       arbiter -> fetcher  request accepted this cycle
//   vram_read_addr        fetcher -> arbiter  word address (ADDR_BITS)
//   vram_read_data        arbiter -> fetcher  returned 32-bit word
//   vram_read_data_valid  arbiter -> fetcher  returned word valid
// Modports
//   master : fetcher side
//   slave  : arbiter side
// ---------------------------------------------------------------------------
interface vdp_scroll_tile_fetcher_if #(
    parameter int ADDR_BITS = 16
);
    logic                 vram_read_valid;
    logic                 vram_read_ready;
    logic [ADDR_BITS-1:0] vram_read_addr;
    logic [31:0]          vram_read_data;
    logic                 vram_read_data_valid;

    modport master (
        output vram_read_valid,
        output vram_read_addr,
        input  vram_read_ready,
        input  vram_read_data,
        input  vram_read_data_valid
    );

    modport slave (
        input  vram_read_valid,
        input  vram_read_addr,
        output vram_read_ready,
        output vram_read_data,
        output vram_read_data_valid
    );
endinterface

// File: rtl/vdp_scroll_tile_fetcher.sv
// ---------------------------------------------------------------------------
// vdp_scroll_tile_fetcher
// Producer side of one scroll layer's pixel path. In every 8-pixel slot it
// reads one map entry and then one 4bpp tile row from VRAM. It hands the row
// and palette to the pixel generator, and it pulses the shifter preload strobe
// at the end of the slot.
//
// Ports
//   clk, reset_n          pixel clock, asynchronous active-low reset
//   line_active           fetching for a visible line
//   raster_x, raster_y    current raster position (10 bits)
//   scroll_x, scroll_y    layer scroll (10 bits)
//   map_base, tile_base   VRAM word addresses of the map and of tile 0 row 0
//   vram_bus              VRAM read channel (master modport)
//   pixel_row             8 x 4bpp row, leftmost pixel in [31:28]
//   palette_number        palette of the fetched tile
//   tile_row_load_enable  strobe: pixel_row valid
//   meta_load_enable      strobe: palette_number valid
//   shifter_preload_load_enable  strobe at slot end (raster_x[2:0] == 7)
//   fetch_underrun        strobe: the slot ended before the fetch completed
// ---------------------------------------------------------------------------
module vdp_scroll_tile_fetcher #(
    parameter int MAP_WIDTH_BITS = 6,
    parameter int ADDR_BITS      = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     line_active,
    input  logic [9:0]               raster_x,
    input  logic [9:0]               raster_y,
    input  logic [9:0]               scroll_x,
    input  logic [9:0]               scroll_y,
    input  logic [ADDR_BITS-1:0]     map_base,
    input  logic [ADDR_BITS-1:0]     tile_base,
    vdp_scroll_tile_fetcher_if.master vram_bus,
    output logic [31:0]              pixel_row,
    output logic [3:0]               palette_number,
    output logic                     tile_row_load_enable,
    output logic                     meta_load_enable,
    output logic                     shifter_preload_load_enable,
    output logic                     fetch_underrun
);
    localparam int MW = MAP_WIDTH_BITS;

    typedef enum logic [2:0] {
        IDLE,
        MAP_REQ,
        MAP_WAIT,
        ROW_REQ,
        ROW_WAIT,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [MW-1:0]       fetch_col_q;
    logic [MW+2:0]       fetch_y_q;
    logic [15:0]         map_entry_q;
    logic [31:0]         row_q;
    logic [3:0]          palette_q;
    logic                strobe_q;
    logic                discard_q;

    logic [9:0]          fetch_x_sum;
    logic [9:0]          fetch_y_sum;
    logic                slot_start;
    logic                slot_end;
    logic                abort;
    logic                start_fetch;
    logic                req_fire;
    logic                data_live;
    logic                capture;
    logic [2:0]          tile_line;
    logic [ADDR_BITS-1:0] map_addr;
    logic [ADDR_BITS-1:0] row_addr;
    logic [31:0]         row_reversed;
    logic                unused_bits;

    // The fetch runs one slot ahead of the pixels being shown, hence the +8.
    assign fetch_x_sum = raster_x + scroll_x + 10'd8;
    assign fetch_y_sum = raster_y + scroll_y;
    assign slot_start  = (raster_x[2:0] == 3'd0);
    assign slot_end    = (raster_x[2:0] == 3'd7);

    // A slot ending without a completed row is an underrun. An idle fetcher
    // only reports it while the line is active. A fetch left in flight after
    // line_active drops is still reported, so that its half-loaded state
    // is flushed.
    assign abort = slot_end && (state != DONE) && (line_active || (state != IDLE));

    assign start_fetch = slot_start && line_active && ((state == IDLE) || abort);

    // A read accepted before an abort still returns its word later.
    // discard_q swallows that word. It also holds off new requests, so that
    // only one read is ever outstanding.
    assign data_live = vram_bus.vram_read_data_valid && !discard_q;
    assign req_fire  = vram_bus.vram_read_valid && vram_bus.vram_read_ready;
    assign capture   = (state == ROW_WAIT) && data_live && !abort;

    assign tile_line = fetch_y_q[2:0] ^ {3{map_entry_q[11]}};
    assign map_addr  = map_base + ADDR_BITS'({fetch_y_q[MW+2:3], fetch_col_q});
    assign row_addr  = tile_base + ADDR_BITS'({map_entry_q[9:0], tile_line});

    // Dropping valid on the slot-end cycle means an unaccepted request can
    // never be accepted in the same cycle that aborts it.
    assign vram_bus.vram_read_valid = ((state == MAP_REQ) || (state == ROW_REQ))
                                      && !discard_q && !slot_end;
    assign vram_bus.vram_read_addr  = (state == MAP_REQ) ? map_addr :
                                      (state == ROW_REQ) ? row_addr : '0;

    // Horizontal flip swaps the pixel order, so the nibble order is reversed.
    always_comb begin
        row_reversed = '0;
        for (int i = 0; i < 8; i++) begin
            row_reversed[4*i +: 4] = vram_bus.vram_read_data[4*(7-i) +: 4];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. An abort overrides the normal sequencing. A new fetch
    // may start in the same cycle as an abort.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = IDLE;
            MAP_REQ:  if (req_fire)  state_next = MAP_WAIT;
            MAP_WAIT: if (data_live) state_next = ROW_REQ;
            ROW_REQ:  if (req_fire)  state_next = ROW_WAIT;
            ROW_WAIT: if (data_live) state_next = DONE;
            DONE:     if (slot_end)  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
        if (start_fetch) begin
            state_next = MAP_REQ;
        end
    end

    // Latch the fetch position and the map entry. Capture the row, and keep
    // the bookkeeping for reads that must be discarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_col_q <= '0;
            fetch_y_q   <= '0;
            map_entry_q <= '0;
            row_q       <= '0;
            palette_q   <= '0;
            strobe_q    <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            if (start_fetch) begin
                fetch_col_q <= fetch_x_sum[MW+2:3];
                fetch_y_q   <= fetch_y_sum[MW+2:0];
            end
            if ((state == MAP_WAIT) && data_live) begin
                map_entry_q <= vram_bus.vram_read_data[15:0];
            end
            if (abort && ((state == MAP_WAIT) || (state == ROW_WAIT))
                && !vram_bus.vram_read_data_valid) begin
                discard_q <= 1'b1;
            end else if (vram_bus.vram_read_data_valid) begin
                discard_q <= 1'b0;
            end
            strobe_q <= capture;
            if (capture) begin
                row_q     <= map_entry_q[10] ? row_reversed : vram_bus.vram_read_data;
                palette_q <= map_entry_q[15:12];
            end else if (abort) begin
                row_q     <= '0;
                palette_q <= '0;
            end
        end
    end

    // On an underrun a blank row is pushed in the same cycle, so that the
    // pixel generator never shows stale pixels.
    assign pixel_row                   = abort ? 32'd0 : row_q;
    assign palette_number              = abort ? 4'd0 : palette_q;
    assign tile_row_load_enable        = strobe_q || abort;
    assign meta_load_enable            = strobe_q || abort;
    assign shifter_preload_load_enable = slot_end && line_active;
    assign fetch_underrun              = abort;

    // Collects the bits of the sums and of the bus that the fetch does not use.
    assign unused_bits = ^{fetch_x_sum, fetch_y_sum, raster_x, vram_bus.vram_read_data[31:16]};
endmodule

// File: tb/tb_vdp_scroll_tile_fetcher.sv
// ---------------------------------------------------------------------------
// tb_vdp_scroll_tile_fetcher
// Directed bench for the scroll tile fetcher. A simple VRAM responder answers
// each accepted request one cycle later. Map-region addresses (below
// tile_base) return map_word, and all other addresses return row_word.
// raster_x advances by one every clock.
// ---------------------------------------------------------------------------
module tb_vdp_scroll_tile_fetcher;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        line_active;
    logic [9:0]  raster_x, raster_y, scroll_x, scroll_y;
    logic [15:0] map_base, tile_base;
    logic [31:0] pixel_row;
    logic [3:0]  palette_number;
    logic        tile_row_load_enable, meta_load_enable;
    logic        shifter_preload_load_enable, fetch_underrun;

    vdp_scroll_tile_fetcher_if #(.ADDR_BITS(16)) vram_bus ();

    vdp_scroll_tile_fetcher #(.MAP_WIDTH_BITS(6), .ADDR_BITS(16)) dut (
        .clk                         (clk),
        .reset_n                     (reset_n),
        .line_active                 (line_active),
        .raster_x                    (raster_x),
        .raster_y                    (raster_y),
        .scroll_x                    (scroll_x),
        .scroll_y                    (scroll_y),
        .map_base                    (map_base),
        .tile_base                   (tile_base),
        .vram_bus                    (vram_bus.master),
        .pixel_row                   (pixel_row),
        .palette_number              (palette_number),
        .tile_row_load_enable        (tile_row_load_enable),
        .meta_load_enable            (meta_load_enable),
        .shifter_preload_load_enable (shifter_preload_load_enable),
        .fetch_underrun              (fetch_underrun)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // VRAM responder controls.
    bit          auto_respond;
    bit          inject_stale;
    logic [31:0] map_word, row_word;

    // Per-slot observations.
    int          req_count, valid_count, strobe_count, preload_count, underrun_count;
    int          row_strobe_x, meta_strobe_x, preload_x, underrun_x;
    logic [15:0] req_addr [4];
    logic [31:0] strobe_row, underrun_row;
    logic [3:0]  strobe_pal;
    logic [15:0] first_valid_addr, prev_addr;
    bit          prev_valid, addr_unstable;

    // Counts one comparison and reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearObs();
        req_count = 0; valid_count = 0; strobe_count = 0;
        preload_count = 0; underrun_count = 0;
        row_strobe_x = -1; meta_strobe_x = -1; preload_x = -1; underrun_x = -1;
        for (int i = 0; i < 4; i++) req_addr[i] = '0;
        strobe_row = '0; underrun_row = 32'hFFFF_FFFF; strobe_pal = '0;
        first_valid_addr = '0; prev_addr = '0; prev_valid = 1'b0; addr_unstable = 1'b0;
    endtask

    task automatic observe();
        if (tile_row_load_enable) begin
            strobe_count++;
            row_strobe_x = int'(raster_x[2:0]);
            strobe_row   = pixel_row;
            strobe_pal   = palette_number;
        end
        if (meta_load_enable) meta_strobe_x = int'(raster_x[2:0]);
        if (shifter_preload_load_enable) begin
            preload_count++;
            preload_x = int'(raster_x[2:0]);
        end
        if (fetch_underrun) begin
            underrun_count++;
            underrun_x   = int'(raster_x[2:0]);
            underrun_row = pixel_row;
        end
        if (vram_bus.vram_read_valid) begin
            valid_count++;
            if (valid_count == 1) first_valid_addr = vram_bus.vram_read_addr;
            else if (prev_valid && vram_bus.vram_read_addr !== prev_addr) addr_unstable = 1'b1;
        end
        prev_valid = vram_bus.vram_read_valid;
        prev_addr  = vram_bus.vram_read_addr;
    endtask

    // Advance one clock. Answer a request accepted at this edge, step
    // raster_x, then sample the outputs for the new cycle.
    task automatic applyStimulus(input int cycles);
        logic        acc;
        logic [15:0] acc_addr;
        for (int c = 0; c < cycles; c++) begin
            acc      = vram_bus.vram_read_valid && vram_bus.vram_read_ready;
            acc_addr = vram_bus.vram_read_addr;
            @(posedge clk);
            #1;
            vram_bus.vram_read_data_valid = 1'b0;
            if (acc && reset_n) begin
                if (req_count < 4) req_addr[req_count] = acc_addr;
                req_count++;
                if (auto_respond) begin
                    vram_bus.vram_read_data_valid = 1'b1;
                    vram_bus.vram_read_data = (acc_addr < tile_base) ? map_word : row_word;
                end
            end
            if (inject_stale) begin
                vram_bus.vram_read_data_valid = 1'b1;
                vram_bus.vram_read_data       = 32'hDEAD_BEEF;
                inject_stale                  = 1'b0;
            end
            raster_x = raster_x + 10'd1;
            #1;
            observe();
        end
    endtask

    initial begin
        reset_n = 1'b0; line_active = 1'b0;
        raster_x = '0; raster_y = '0; scroll_x = '0; scroll_y = '0;
        map_base = 16'h1000; tile_base = 16'h2000;
        vram_bus.vram_read_ready = 1'b1;
        vram_bus.vram_read_data = '0;
        vram_bus.vram_read_data_valid = 1'b0;
        auto_respond = 1'b1; inject_stale = 1'b0;
        map_word = 32'h0000_3007; row_word = 32'h89AB_CDEF;
        clearObs();

        // Reset state
        #22;
        checkOutput("reset_valid",    32'(vram_bus.vram_read_valid), 32'd0);
        checkOutput("reset_addr",     32'(vram_bus.vram_read_addr),  32'd0);
        checkOutput("reset_row",      pixel_row,                     32'd0);
        checkOutput("reset_pal",      32'(palette_number),           32'd0);
        checkOutput("reset_strobes",  32'({tile_row_load_enable, meta_load_enable,
                                           shifter_preload_load_enable, fetch_underrun}), 32'd0);

        // 1: basic fetch, tile 7 row 0, palette 3
        @(posedge clk); #1;
        reset_n = 1'b1; line_active = 1'b1; raster_x = '0;
        #1;
        clearObs();
        applyStimulus(8);
        checkOutput("t1_req_count",  32'(req_count),   32'd2);
        checkOutput("t1_map_addr",   32'(req_addr[0]), 32'h1001);
        checkOutput("t1_row_addr",   32'(req_addr[1]), 32'h2038);
        checkOutput("t1_row_x",      32'(row_strobe_x), 32'd5);
        checkOutput("t1_meta_x",     32'(meta_strobe_x), 32'd5);
        checkOutput("t1_row",        strobe_row,       32'h89AB_CDEF);
        checkOutput("t1_pal",        32'(strobe_pal),  32'd3);
        checkOutput("t1_preload_x",  32'(preload_x),   32'd7);
        checkOutput("t1_underrun",   32'(underrun_count), 32'd0);

        // 2: map word 0x5C03, fetch_y[2:0]=2, so vflip gives row 5 and hflip reverses
        raster_y = 10'd2;
        map_word = 32'h0000_5C03; row_word = 32'h0123_4567;
        clearObs();
        applyStimulus(8);
        checkOutput("t2_map_addr",   32'(req_addr[0]), 32'h1002);
        checkOutput("t2_row_addr",   32'(req_addr[1]), 32'h201D);
        checkOutput("t2_row",        strobe_row,       32'h7654_3210);
        checkOutput("t2_pal",        32'(strobe_pal),  32'd5);

        // 3: arbiter stalls for the whole slot
        raster_y = '0;
        vram_bus.vram_read_ready = 1'b0;
        clearObs();
        applyStimulus(7);
        checkOutput("t3_accepted",    32'(req_count),      32'd0);
        checkOutput("t3_valid_cycles",32'(valid_count),    32'd6);
        checkOutput("t3_addr",        32'(first_valid_addr), 32'h1003);
        checkOutput("t3_addr_stable", 32'(addr_unstable),  32'd0);
        checkOutput("t3_underrun",    32'(underrun_count), 32'd1);
        checkOutput("t3_underrun_x",  32'(underrun_x),     32'd7);
        checkOutput("t3_zero_row",    underrun_row,        32'd0);
        checkOutput("t3_strobe_x",    32'(row_strobe_x),   32'd7);
        checkOutput("t3_preload_x",   32'(preload_x),      32'd7);
        vram_bus.vram_read_ready = 1'b1;
        inject_stale = 1'b1;
        clearObs();
        applyStimulus(1);
        clearObs();
        applyStimulus(8);
        checkOutput("t3_next_map",   32'(req_addr[0]), 32'h1004);
        checkOutput("t3_next_rowad", 32'(req_addr[1]), 32'h201F);
        checkOutput("t3_next_row",   strobe_row,       32'h7654_3210);
        checkOutput("t3_next_ur",    32'(underrun_count), 32'd0);

        // 4: x and y wrap: fetch_x=4 gives column 0, fetch_y=76 gives map row 9, tile row 4
        raster_x = '0; scroll_x = 10'd1020; raster_y = 10'd1000; scroll_y = 10'd100;
        map_word = 32'h0000_9001; row_word = 32'h1357_9BDF;
        clearObs();
        applyStimulus(8);
        checkOutput("t4_map_addr",   32'(req_addr[0]), 32'h1240);
        checkOutput("t4_row_addr",   32'(req_addr[1]), 32'h200C);
        checkOutput("t4_row",        strobe_row,       32'h1357_9BDF);
        checkOutput("t4_pal",        32'(strobe_pal),  32'd9);

        // 5: reset during ROW_WAIT, then a stale return arrives
        scroll_x = '0; scroll_y = '0; raster_y = '0;
        clearObs();
        applyStimulus(4);
        checkOutput("t5_pre_strobe", 32'(strobe_count), 32'd0);
        reset_n = 1'b0; line_active = 1'b0; auto_respond = 1'b0;
        vram_bus.vram_read_data_valid = 1'b0;
        #1;
        checkOutput("t5_rst_valid",  32'(vram_bus.vram_read_valid), 32'd0);
        checkOutput("t5_rst_row",    pixel_row,                     32'd0);
        checkOutput("t5_rst_strb",   32'({tile_row_load_enable, meta_load_enable}), 32'd0);
        applyStimulus(1);
        reset_n = 1'b1;
        inject_stale = 1'b1;
        clearObs();
        applyStimulus(3);
        checkOutput("t5_no_strobe",  32'(strobe_count),   32'd0);
        checkOutput("t5_no_ur",      32'(underrun_count), 32'd0);
        checkOutput("t5_no_req",     32'(valid_count),    32'd0);
        checkOutput("t5_row_zero",   pixel_row,           32'd0);
        checkOutput("t5_pal_zero",   32'(palette_number), 32'd0);
        line_active = 1'b1; auto_respond = 1'b1;
        map_word = 32'h0000_2004; row_word = 32'hCAFE_F00D;
        clearObs();
        applyStimulus(8);
        checkOutput("t5_next_map",   32'(req_addr[0]),  32'h1003);
        checkOutput("t5_next_rowad", 32'(req_addr[1]),  32'h2020);
        checkOutput("t5_next_row",   strobe_row,        32'hCAFE_F00D);
        checkOutput("t5_next_pal",   32'(strobe_pal),   32'd2);
        checkOutput("t5_next_x",     32'(row_strobe_x), 32'd5);

        // 6: line inactive for three slots
        line_active = 1'b0;
        clearObs();
        applyStimulus(24);
        checkOutput("t6_no_req",     32'(valid_count),    32'd0);
        checkOutput("t6_no_preload", 32'(preload_count),  32'd0);
        checkOutput("t6_no_strobe",  32'(strobe_count),   32'd0);
        checkOutput("t6_no_ur",      32'(underrun_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
